skin_coord_gen: RTL

SKIN_COORD_GEN -- requirements
Module: skin_coord_gen

---
 rtl/skin_coord_gen_if.sv | 30 +++
 rtl/skin_coord_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/skin_coord_gen_if.sv
// Pixel-in / coordinate-out bus of skin_coord_gen.
interface skin_coord_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PIX_WIDTH  = 8
);
    logic                  pix_valid;
    logic                  pix_sof;
    logic [PIX_WIDTH-1:0]  pix_y;
    logic [PIX_WIDTH-1:0]  pix_cb;
    logic [PIX_WIDTH-1:0]  pix_cr;
    logic                  pix_ready;
    logic [DATA_WIDTH-1:0] coord_x;
    logic [DATA_WIDTH-1:0] coord_y;
    logic                  coord_enable;
    logic                  coord_end;
    logic                  frame_empty;
    logic                  frame_err;

    // Pixel source / coordinate sink side.
    modport master (
        output pix_valid, pix_sof, pix_y, pix_cb, pix_cr,
        input  pix_ready, coord_x, coord_y, coord_enable, coord_end, frame_empty, frame_err
    );

    // Classifier side.
    modport slave (
        input  pix_valid, pix_sof, pix_y, pix_cb, pix_cr,
        output pix_ready, coord_x, coord_y, coord_enable, coord_end, frame_empty, frame_err
    );
endinterface

// File: rtl/skin_coord_gen.sv
// skin_coord_gen: classifies a YCbCr pixel stream as skin / non-skin and emits
// the frame position of every skin pixel, followed by an end-of-frame marker.
module skin_coord_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int PIX_WIDTH  = 8,
    parameter int FRAME_W    = 256,
    parameter int FRAME_H    = 256,
    parameter int Y_MIN      = 40,
    parameter int CB_MIN     = 77,
    parameter int CB_MAX     = 127,
    parameter int CR_MIN     = 133,
    parameter int CR_MAX     = 173
) (
    input logic             clk,
    input logic             rst,
    skin_coord_gen_if.slave bus
);
    // One extra bit so a counter can hold FRAME_W / FRAME_H when they equal 2^DATA_WIDTH.
    localparam int CW = DATA_WIDTH + 1;
    localparam logic [CW-1:0] X_LAST = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(FRAME_H - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    localparam logic [PIX_WIDTH-1:0] Y_LO  = PIX_WIDTH'(Y_MIN);
    localparam logic [PIX_WIDTH-1:0] CB_LO = PIX_WIDTH'(CB_MIN);
    localparam logic [PIX_WIDTH-1:0] CB_HI = PIX_WIDTH'(CB_MAX);
    localparam logic [PIX_WIDTH-1:0] CR_LO = PIX_WIDTH'(CR_MIN);
    localparam logic [PIX_WIDTH-1:0] CR_HI = PIX_WIDTH'(CR_MAX);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_END} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         x_q, x_d, y_q, y_d;
    logic                  match_flag_q, match_flag_d;
    logic [DATA_WIDTH-1:0] coord_x_q, coord_x_d, coord_y_q, coord_y_d;
    logic                  coord_enable_q, coord_enable_d;
    logic                  coord_end_q, coord_end_d;
    logic                  frame_empty_q, frame_empty_d;
    logic                  frame_err_q, frame_err_d;

    logic                  pix_ready;
    logic                  beat;       // pixel accepted this cycle
    logic                  take;       // accepted pixel that belongs to a frame
    logic                  is_match;
    logic                  last_beat;
    logic [CW-1:0]         pos_x, pos_y;

    // Beat qualification, pixel position and skin test for the pixel on the bus.
    always_comb begin
        beat      = bus.pix_valid && pix_ready;
        take      = beat && (bus.pix_sof || state_q == ST_ACTIVE);
        pos_x     = bus.pix_sof ? '0 : x_q;
        pos_y     = bus.pix_sof ? '0 : y_q;
        is_match  = (bus.pix_y >= Y_LO)
                 && (bus.pix_cb >= CB_LO) && (bus.pix_cb <= CB_HI)
                 && (bus.pix_cr >= CR_LO) && (bus.pix_cr <= CR_HI);
        last_beat = take && (pos_x == X_LAST) && (pos_y == Y_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: a sof beat opens a frame, the last position closes it, END lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (take) state_d = last_beat ? ST_END : ST_ACTIVE;
            ST_ACTIVE: if (last_beat) state_d = ST_END;
            ST_END:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM output: the only unregistered output, decoded from the state.
    always_comb begin
        pix_ready = (state_q != ST_END);
    end

    // Datapath next-state: position counters, match flag and registered outputs.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        x_d            = x_q;
        y_d            = y_q;
        match_flag_d   = match_flag_q;
        coord_x_d      = coord_x_q;
        coord_y_d      = coord_y_q;
        coord_enable_d = 1'b0;
        coord_end_d    = (state_q == ST_END);
        frame_empty_d  = (state_q == ST_END) && !match_flag_q;
        frame_err_d    = beat && bus.pix_sof && (state_q == ST_ACTIVE);
        if (take) begin
            match_flag_d = (bus.pix_sof ? 1'b0 : match_flag_q) | is_match;
            if (is_match) begin
                coord_enable_d = 1'b1;
                coord_x_d      = pos_x[DATA_WIDTH-1:0];
                coord_y_d      = pos_y[DATA_WIDTH-1:0];
            end
            if (last_beat) begin
                x_d = '0;
                y_d = '0;
            end else if (pos_x == X_LAST) begin
                x_d = '0;
                y_d = pos_y + ONE;
            end else begin
                x_d = pos_x + ONE;
                y_d = pos_y;
            end
        end
    end

    // Datapath registers; reset clears the pipeline at once so an interrupted frame leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q            <= '0;
            y_q            <= '0;
            match_flag_q   <= 1'b0;
            coord_x_q      <= '0;
            coord_y_q      <= '0;
            coord_enable_q <= 1'b0;
            coord_end_q    <= 1'b0;
            frame_empty_q  <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            x_q            <= x_d;
            y_q            <= y_d;
            match_flag_q   <= match_flag_d;
            coord_x_q      <= coord_x_d;
            coord_y_q      <= coord_y_d;
            coord_enable_q <= coord_enable_d;
            coord_end_q    <= coord_end_d;
            frame_empty_q  <= frame_empty_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign bus.pix_ready    = pix_ready;
    assign bus.coord_x      = coord_x_q;
    assign bus.coord_y      = coord_y_q;
    assign bus.coord_enable = coord_enable_q;
    assign bus.coord_end    = coord_end_q;
    assign bus.frame_empty  = frame_empty_q;
    assign bus.frame_err    = frame_err_q;
endmodule
